hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Producer side of the per-stage hazard_control bus that every pipeline stage register consumes.
//  - bit `HAZD_HOLD_BIT` (=0): keep the stage register contents.
//  - bit `HAZD_NO_OP_BIT` (=1): mark the downstream stage as a bubble.
//  Detects load-use, ID-resolved branch/jump and slow-memory hazards. Sequences multi-cycle memory
//  stalls with a timeout FSM and keeps a saturating stall-cycle counter.
// PARAMETERS
//  REG_FILE_ADDR_WIDTH  5    register index width (matches `REG_FILE_ADDR_WIDTH)
//  MEM_TIMEOUT          255  max MEM_WAIT cycles before forced abort, range 2..255
//  STALL_CNT_WIDTH      16   width of stall_cycles performance counter
// PORTS
//  clk                  in   1   pipeline clock, all state on rising edge
//  rst                  in   1   asynchronous, active-high reset
//  id_reg_1_idx         in   RA  first source register of instruction in ID
//  id_reg_2_idx         in   RA  second source register of instruction in ID
//  ex_mem_read          in   1   instruction in EX is a load (ex_mem_control[1])
//  ex_reg_dest_idx      in   RA  destination register of instruction in EX
//  id_branch_taken      in   1   branch/jump resolved taken in ID this cycle
//  mem_req              in   1   MEM stage issues access to a multi-cycle device (UART/IO)
//  mem_ready            in   1   device completes access (may be same cycle as mem_req)
//  pc_hazard            out  2   hazard_control for PC register
//  if_id_hazard         out  2   hazard_control for if_id_reg
//  id_ex_hazard         out  2   hazard_control for id_ex_reg
//  ex_mem_hazard        out  2   hazard_control for ex_mem_reg
//  mem_wb_hazard        out  2   hazard_control for mem_wb_reg
//  mem_timeout          out  1   one-cycle pulse: memory access aborted by timeout
//  stall_cycles         out  SW  saturating count of cycles with pc_hazard[HOLD]=1
// BEHAVIOUR
//  Reset (async, while rst=1):
//   - state=NORMAL, wait_cnt=0, mem_timeout=0, stall_cycles=0.
//   - All *_hazard outputs are forced 2'b00.
//  Hazard outputs are combinational from state and inputs (same-cycle effect). Counters and state
//  are registered.
//  load_use = ex_mem_read & (ex_reg_dest_idx!=0) & (ex_reg_dest_idx==id_reg_1_idx | ex_reg_dest_idx==id_reg_2_idx).
//  mem_stall = mem_req & ~mem_ready.
//  State NORMAL, priority mem_stall > load_use > id_branch_taken > none:
//   - mem_stall: pc/if_id/id_ex/ex_mem=01, mem_wb=10; next=MEM_WAIT, wait_cnt<=1.
//   - load_use: pc/if_id=01, id_ex=11 (discard ID result, bubble EX), others 00; stays NORMAL.
//     Repeats every cycle the condition holds.
//   - id_branch_taken: if_id=10 (flush wrong-path fetch), others 00.
//   - none: all 00.
//  State MEM_WAIT:
//   - mem_ready=1: all 00 this cycle; next=NORMAL, wait_cnt<=0.
//   - else if wait_cnt==MEM_TIMEOUT-1: pc/if_id/id_ex=01, ex_mem=00, mem_wb=10;
//     mem_timeout<=1 (pulse next cycle); next=NORMAL.
//   - else: same outputs as NORMAL mem_stall; wait_cnt<=wait_cnt+1.
//   - load_use and id_branch_taken are ignored while in MEM_WAIT; the frozen pipeline re-evaluates
//     them on return to NORMAL.
//  Simultaneous mem_req & mem_ready in NORMAL: no stall, no state change.
//  stall_cycles: +1 each cycle pc_hazard[0]=1; saturates at all-ones, no wrap.
//  Illegal state encoding: recover to NORMAL next cycle.
//  Reset mid-MEM_WAIT: immediate return to NORMAL, outputs 00, pending access dropped.
// TESTING
//  1. Load r5 in EX, ID reads r5 -> pc/if_id=01, id_ex=11 one cycle; stall_cycles=1.
//     Same with r0 -> all 00.
//  2. id_branch_taken=1, no other hazard -> if_id=10, pc=00, id_ex=00.
//  3. mem_req=1, mem_ready low 3 cycles then high -> 3 cycles pc..ex_mem=01, mem_wb=10,
//     then all 00 and state NORMAL.
//  4. MEM_TIMEOUT=4, mem_ready never high -> abort in 4th stall cycle; mem_timeout pulses 1 cycle;
//     NORMAL after.
//  5. mem_stall and load_use together -> mem outputs win; rst pulsed mid-MEM_WAIT -> outputs 00
//     immediately, counters 0.
//  6. Force 2^16+5 stall cycles -> stall_cycles holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_if.sv
// Hazard-control bus between the hazard unit and the pipeline stage registers.
// The master side belongs to the hazard unit, the slave side to the pipeline.
interface hazard_if #(
    parameter int unsigned RA = 5,
    parameter int unsigned SW = 16
);
    logic [RA-1:0] id_reg_1_idx;
    logic [RA-1:0] id_reg_2_idx;
    logic          ex_mem_read;
    logic [RA-1:0] ex_reg_dest_idx;
    logic          id_branch_taken;
    logic          mem_req;
    logic          mem_ready;

    logic [1:0]    pc_hazard;
    logic [1:0]    if_id_hazard;
    logic [1:0]    id_ex_hazard;
    logic [1:0]    ex_mem_hazard;
    logic [1:0]    mem_wb_hazard;
    logic          mem_timeout;
    logic [SW-1:0] stall_cycles;

    modport master (
        input  id_reg_1_idx, id_reg_2_idx, ex_mem_read, ex_reg_dest_idx,
               id_branch_taken, mem_req, mem_ready,
        output pc_hazard, if_id_hazard, id_ex_hazard, ex_mem_hazard, mem_wb_hazard,
               mem_timeout, stall_cycles
    );

    modport slave (
        output id_reg_1_idx, id_reg_2_idx, ex_mem_read, ex_reg_dest_idx,
               id_branch_taken, mem_req, mem_ready,
        input  pc_hazard, if_id_hazard, id_ex_hazard, ex_mem_hazard, mem_wb_hazard,
               mem_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use, taken-branch flush and slow-memory stalls with a
// timeout FSM, plus a saturating count of cycles in which the PC was held.
module hazard_unit #(
    parameter int unsigned REG_FILE_ADDR_WIDTH = 5,
    parameter int unsigned MEM_TIMEOUT         = 255,
    parameter int unsigned STALL_CNT_WIDTH     = 16
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.master bus
);
    localparam int unsigned HOLD_BIT = 0;

    typedef logic [1:0] hz_t;
    localparam hz_t HZ_NONE    = 2'b00;
    localparam hz_t HZ_HOLD    = 2'b01;
    localparam hz_t HZ_BUBBLE  = 2'b10;
    localparam hz_t HZ_DISCARD = 2'b11;

    // Last MEM_WAIT count before the access is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        NORMAL   = 2'b00,
        MEM_WAIT = 2'b01
    } state_t;

    state_t                       state_q, state_d;
    logic [7:0]                   wait_cnt_q, wait_cnt_d;
    logic                         timeout_q, timeout_d;
    logic [STALL_CNT_WIDTH-1:0]   stall_q;

    logic [REG_FILE_ADDR_WIDTH-1:0] id_rs1, id_rs2, ex_rd;
    logic                           load_use;
    logic                           mem_stall;

    hz_t pc_d, if_id_d, id_ex_d, ex_mem_d, mem_wb_d;

    assign id_rs1 = bus.id_reg_1_idx;
    assign id_rs2 = bus.id_reg_2_idx;
    assign ex_rd  = bus.ex_reg_dest_idx;

    // r0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign load_use  = bus.ex_mem_read && (ex_rd != '0) &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign mem_stall = bus.mem_req && !bus.mem_ready;

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = 1'b0;
        pc_d       = HZ_NONE;
        if_id_d    = HZ_NONE;
        id_ex_d    = HZ_NONE;
        ex_mem_d   = HZ_NONE;
        mem_wb_d   = HZ_NONE;

        case (state_q)
            NORMAL: begin
                if (mem_stall) begin
                    pc_d       = HZ_HOLD;
                    if_id_d    = HZ_HOLD;
                    id_ex_d    = HZ_HOLD;
                    ex_mem_d   = HZ_HOLD;
                    mem_wb_d   = HZ_BUBBLE;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else if (load_use) begin
                    pc_d    = HZ_HOLD;
                    if_id_d = HZ_HOLD;
                    id_ex_d = HZ_DISCARD;
                end else if (bus.id_branch_taken) begin
                    if_id_d = HZ_BUBBLE;
                end
            end

            // Load-use and branch inputs are ignored here; the frozen pipeline
            // presents them again once the memory access is over.
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_d    = NORMAL;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Abort: EX/MEM advances so the dead access leaves MEM.
                    pc_d       = HZ_HOLD;
                    if_id_d    = HZ_HOLD;
                    id_ex_d    = HZ_HOLD;
                    mem_wb_d   = HZ_BUBBLE;
                    timeout_d  = 1'b1;
                    state_d    = NORMAL;
                    wait_cnt_d = '0;
                end else begin
                    pc_d       = HZ_HOLD;
                    if_id_d    = HZ_HOLD;
                    id_ex_d    = HZ_HOLD;
                    ex_mem_d   = HZ_HOLD;
                    mem_wb_d   = HZ_BUBBLE;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d    = NORMAL;
                wait_cnt_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= NORMAL;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            if (pc_d[HOLD_BIT] && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    // Hazard controls are forced idle for the whole time reset is asserted.
    assign bus.pc_hazard     = rst ? HZ_NONE : pc_d;
    assign bus.if_id_hazard  = rst ? HZ_NONE : if_id_d;
    assign bus.id_ex_hazard  = rst ? HZ_NONE : id_ex_d;
    assign bus.ex_mem_hazard = rst ? HZ_NONE : ex_mem_d;
    assign bus.mem_wb_hazard = rst ? HZ_NONE : mem_wb_d;
    assign bus.mem_timeout   = timeout_q;
    assign bus.stall_cycles  = stall_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the hazard rules.
module tb_hazard_unit;
    localparam int TO   = 4;
    localparam int SW   = 16;
    localparam int MAXC = 65535;

    localparam logic [9:0] P_NONE  = 10'b00_00_00_00_00;
    localparam logic [9:0] P_STALL = 10'b01_01_01_01_10;
    localparam logic [9:0] P_LU    = 10'b01_01_11_00_00;
    localparam logic [9:0] P_BR    = 10'b00_10_00_00_00;
    localparam logic [9:0] P_ABORT = 10'b01_01_01_00_10;

    logic clk;
    logic rst;

    hazard_if #(.RA(5), .SW(SW)) bus ();

    hazard_unit #(
        .REG_FILE_ADDR_WIDTH(5),
        .MEM_TIMEOUT        (TO),
        .STALL_CNT_WIDTH    (SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] hz_all;
    assign hz_all = {bus.pc_hazard, bus.if_id_hazard, bus.id_ex_hazard,
                     bus.ex_mem_hazard, bus.mem_wb_hazard};

    int n_checks;
    int n_fail;

    // Reference model: whether an access is outstanding, how many cycles it has
    // waited, the pending timeout pulse and the stall tally.
    bit m_wait;
    int m_cnt;
    bit m_tmo;
    int m_stalls;

    function automatic void model_reset();
        m_wait   = 1'b0;
        m_cnt    = 0;
        m_tmo    = 1'b0;
        m_stalls = 0;
    endfunction

    function automatic bit model_load_use();
        return bus.ex_mem_read && (bus.ex_reg_dest_idx != 5'd0) &&
               ((bus.ex_reg_dest_idx == bus.id_reg_1_idx) ||
                (bus.ex_reg_dest_idx == bus.id_reg_2_idx));
    endfunction

    function automatic logic [9:0] model_hz();
        if (rst) return P_NONE;
        if (!m_wait) begin
            if (bus.mem_req && !bus.mem_ready) return P_STALL;
            if (model_load_use())               return P_LU;
            if (bus.id_branch_taken)            return P_BR;
            return P_NONE;
        end
        if (bus.mem_ready)  return P_NONE;
        if (m_cnt == TO - 1) return P_ABORT;
        return P_STALL;
    endfunction

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic tick();
        logic [9:0] e;
        bit         ms;
        bit         fire;
        e    = model_hz();
        ms   = bus.mem_req && !bus.mem_ready;
        fire = m_wait && !bus.mem_ready && (m_cnt == TO - 1);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e[8] && (m_stalls < MAXC)) m_stalls++;
            m_tmo = fire;
            if (!m_wait) begin
                if (ms) begin
                    m_wait = 1'b1;
                    m_cnt  = 1;
                end
            end else if (bus.mem_ready || fire) begin
                m_wait = 1'b0;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic ld,
                         input logic [4:0] rd, input logic br, input logic req,
                         input logic rdy);
        bus.id_reg_1_idx    = rs1;
        bus.id_reg_2_idx    = rs2;
        bus.ex_mem_read     = ld;
        bus.ex_reg_dest_idx = rd;
        bus.id_branch_taken = br;
        bus.mem_req         = req;
        bus.mem_ready       = rdy;
    endtask

    task automatic drive_idle();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (hz_all !== P_NONE) begin
            n_fail++; $display("FAIL reset_hz got=%b exp=%b", hz_all, P_NONE);
        end
        n_checks++;
        if (bus.stall_cycles !== 16'd0 || bus.mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_cnt got stall=%0d tmo=%b exp 0/0", bus.stall_cycles, bus.mem_timeout);
        end
        rst = 1'b0;
        drive_idle();
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.stall_cycles !== 16'd0) begin
            n_fail++; $display("FAIL reset_release stall got=%0d exp=0", bus.stall_cycles);
        end
        tick();
    endtask

    task automatic test_load_use();
        drive(5'd5, 5'd3, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (hz_all !== P_LU) begin
            n_fail++; $display("FAIL load_use_rs1 got=%b exp=%b", hz_all, P_LU);
        end
        tick();
        drive_idle();
        @(negedge clk);
        n_checks++;
        if (hz_all !== P_NONE || bus.stall_cycles !== 16'd1) begin
            n_fail++; $display("FAIL load_use_after got hz=%b stall=%0d exp hz=%b stall=1", hz_all, bus.stall_cycles, P_NONE);
        end
        tick();
        drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (hz_all !== P_NONE) begin
            n_fail++; $display("FAIL load_use_r0 got=%b exp=%b", hz_all, P_NONE);
        end
        tick();
        drive(5'd7, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (hz_all !== P_LU) begin
            n_fail++; $display("FAIL load_use_rs2 got=%b exp=%b", hz_all, P_LU);
        end
        tick();
        drive(5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (hz_all !== P_NONE || bus.stall_cycles !== 16'd2) begin
            n_fail++; $display("FAIL no_load got hz=%b stall=%0d exp hz=%b stall=2", hz_all, bus.stall_cycles, P_NONE);
        end
        tick();
    endtask

    task automatic test_branch();
        drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (bus.if_id_hazard !== 2'b10 || bus.pc_hazard !== 2'b00 || bus.id_ex_hazard !== 2'b00 || hz_all !== P_BR) begin
            n_fail++; $display("FAIL branch got=%b exp=%b", hz_all, P_BR);
        end
        tick();
        drive(5'd4, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (hz_all !== P_LU) begin
            n_fail++; $display("FAIL branch_vs_load_use got=%b exp=%b", hz_all, P_LU);
        end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_mem_stall();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (hz_all !== P_STALL) begin
                n_fail++; $display("FAIL mem_stall_c%0d got=%b exp=%b", i, hz_all, P_STALL);
            end
            tick();
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (hz_all !== P_NONE) begin
            n_fail++; $display("FAIL mem_ready_release got=%b exp=%b", hz_all, P_NONE);
        end
        tick();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (hz_all !== P_BR) begin
            n_fail++; $display("FAIL mem_back_to_normal got=%b exp=%b", hz_all, P_BR);
        end
        tick();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++;
        if (hz_all !== P_NONE) begin
            n_fail++; $display("FAIL mem_same_cycle got=%b exp=%b", hz_all, P_NONE);
        end
        tick();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (hz_all !== P_BR) begin
            n_fail++; $display("FAIL mem_same_cycle_state got=%b exp=%b", hz_all, P_BR);
        end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_timeout();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            n_checks++;
            if (hz_all !== ((i == TO - 1) ? P_ABORT : P_STALL) || bus.mem_timeout !== 1'b0) begin
                n_fail++; $display("FAIL timeout_c%0d got hz=%b tmo=%b exp hz=%b tmo=0", i, hz_all, bus.mem_timeout,
                                   (i == TO - 1) ? P_ABORT : P_STALL);
            end
            tick();
        end
        drive_idle();
        @(negedge clk);
        n_checks++;
        if (bus.mem_timeout !== 1'b1 || hz_all !== P_NONE) begin
            n_fail++; $display("FAIL timeout_pulse got tmo=%b hz=%b exp tmo=1 hz=%b", bus.mem_timeout, hz_all, P_NONE);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_pulse_end got=%b exp=0", bus.mem_timeout);
        end
        tick();
    endtask

    task automatic test_priority_and_reset();
        drive(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (hz_all !== P_STALL) begin
                n_fail++; $display("FAIL mem_priority_c%0d got=%b exp=%b", i, hz_all, P_STALL);
            end
            tick();
        end
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (hz_all !== P_NONE || bus.stall_cycles !== 16'd0 || bus.mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL mid_wait_reset got hz=%b stall=%0d tmo=%b exp all 0", hz_all, bus.stall_cycles, bus.mem_timeout);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        tick();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (hz_all !== P_BR || bus.stall_cycles !== 16'd0) begin
            n_fail++; $display("FAIL after_reset_normal got hz=%b stall=%0d exp hz=%b stall=0", hz_all, bus.stall_cycles, P_BR);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 4));
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if (hz_all !== model_hz()) begin
                n_fail++; $display("FAIL random_hz cyc=%0d got=%b exp=%b", i, hz_all, model_hz());
            end
            n_checks++;
            if (bus.mem_timeout !== m_tmo || bus.stall_cycles !== 16'(m_stalls)) begin
                n_fail++; $display("FAIL random_cnt cyc=%0d got tmo=%b stall=%0d exp tmo=%b stall=%0d",
                                   i, bus.mem_timeout, bus.stall_cycles, m_tmo, m_stalls);
            end
            tick();
        end
        rst = 1'b0;
        drive_idle();
        tick();
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(5'd6, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
        repeat (MAXC - 1) tick();
        @(negedge clk);
        n_checks++;
        if (bus.stall_cycles !== 16'hFFFE) begin
            n_fail++; $display("FAIL sat_minus_one got=%h exp=fffe", bus.stall_cycles);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.stall_cycles !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_reach got=%h exp=ffff", bus.stall_cycles);
        end
        repeat (6) tick();
        @(negedge clk);
        n_checks++;
        if (bus.stall_cycles !== 16'hFFFF || bus.stall_cycles !== 16'(m_stalls)) begin
            n_fail++; $display("FAIL sat_hold got=%h exp=ffff", bus.stall_cycles);
        end
        drive_idle();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive_idle();
        model_reset();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_stall();
        test_timeout();
        test_priority_and_reset();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
